video_rx_monitor: RTL and testbench
===================================

Name: video_rx_monitor

Overview:
- Receiving end of the team's video interface: samples HS/VS/BLANK/RGB driven by the VGA timing generator, or by any video_if master, in the same pixel_clk domain.
- Reconstructs active-pixel coordinates and measures line and frame geometry.
- Compares the geometry against the expected resolution and reports lock and sticky error status.
- Used as an in-system checker and as the front end of future pixel-capture and overlay blocks.

Parameters:
- HDISP, 800, expected active pixels per line.
- VDISP, 480, expected active lines per frame.
- HCNT_W, 12, width of horizontal counters (saturating).
- VCNT_W, 11, width of vertical counters (saturating).
- LOCK_FRAMES, 2, consecutive good frames required to assert locked.

Ports:
- pixel_clk  input  1  pixel clock; all logic on its rising edge.
- pixel_rst  input  1  asynchronous, active-high reset.
- hs  input  1  horizontal sync, active low.
- vs  input  1  vertical sync, active low.
- blank  input  1  1 = active (visible) pixel, 0 = blanking.
- rgb  input  24  pixel data {R,G,B}, 8 bits each.
- err_clr  input  1  synchronous pulse; clears h_err/v_err/timeout.
- pix_valid  output  1  registered copy of an active pixel.
- pix_x  output  HCNT_W  column of pixel on pix_valid, 0..HDISP-1.
- pix_y  output  VCNT_W  row of pixel on pix_valid, 0..VDISP-1.
- pix_rgb  output  24  rgb of that pixel.
- frame_start  output  1  one-cycle pulse on each detected VS falling edge.
- h_total  output  HCNT_W  clocks between last two HS falling edges.
- v_total  output  VCNT_W  HS falling edges in last complete frame.
- h_active  output  HCNT_W  active pixels of last line with nonzero count.
- v_active  output  VCNT_W  active lines in last complete frame.
- locked  output  1  geometry matched for LOCK_FRAMES consecutive frames.
- h_err  output  1  sticky: a line had active count not equal to HDISP while in MEASURE/LOCKED.
- v_err  output  1  sticky: a frame had active lines not equal to VDISP while in MEASURE/LOCKED.
- timeout  output  1  sticky: horizontal counter saturated (no HS).

Behaviour:
- Reset value of every output is 0, and every internal counter is 0. FSM resets to SEARCH.
- Input stage: hs/vs/blank/rgb are registered once (stage 1). Falling edges are detected against a second register (stage 2). The sync registers reset to 1 so reset release creates no false edge.
- Latency: pix_valid/pix_x/pix_y/pix_rgb are registered and appear 2 pixel_clk after the input sample. frame_start and measurement updates also lag 2 cycles.
- hcnt increments every cycle and clears on HS fall; at that moment its value +1 is latched into h_total.
- act_x counts stage-1 blank=1 cycles. pix_x = act_x before increment.
- At HS fall:
  - if act_x != 0, latch h_active, increment line_act (gives pix_y for the next active line), and flag line_bad if act_x != HDISP;
  - then clear act_x.
- At VS fall:
  - latch v_total = HS falls since the previous VS fall, and v_active = line_act;
  - clear those counters and pulse frame_start.
- FSM (evaluated at VS fall):
  - SEARCH: the first VS fall moves to MEASURE without evaluating the partial frame. good_cnt=0.
  - MEASURE: a good frame (no line_bad and line_act==VDISP) increments good_cnt; good_cnt==LOCK_FRAMES moves to LOCKED and sets locked=1. A bad frame sets good_cnt=0.
  - LOCKED: a bad frame moves to MEASURE, sets locked=0 and good_cnt=0.
  - In any state, a timeout moves to SEARCH and sets locked=0.
- h_err/v_err set when a bad line/frame is evaluated in MEASURE/LOCKED. SEARCH never sets them. line_bad clears at each VS fall.
- Counters saturate at all ones and never wrap. hcnt reaching all ones sets timeout.
- Same-cycle HS fall and VS fall: the line-end update is applied first, so that line counts in the closing frame. The frame-end update is then applied in the same cycle.
- err_clr coinciding with a new error: the set wins.
- Reset mid-frame: everything returns to reset values. SEARCH discards the partial frame.
- Active pixels beyond HDISP still produce pix_valid, with pix_x saturating at all ones. This counts as an h_err condition.

Decomposition:
- Shared package video_pkg holds:
  - HDISP/VDISP defaults and the HFP/HPULSE/HBP/VFP/VPULSE/VBP constants shared with the generator;
  - HCNT_W/VCNT_W;
  - typedef rgb_t (logic [23:0]);
  - the FSM enum rx_state_t {SEARCH, MEASURE, LOCKED}.
- One sub-module, sync_edge_det: a two-register sampler with a falling-edge pulse, reset-to-1. It is instantiated for hs and vs.

Test Plan:
- Nominal 800x480 stream (928 clocks/line, 525 lines/frame, HS low 48, VS low 3): locked rises at the 3rd VS fall + 2 cycles; h_total=928, v_total=525, h_active=800, v_active=480; no errors.
- Coordinates: the first active pixel gives pix_valid with x=0, y=0, and rgb equal to the input 2 cycles later; the last active pixel gives x=799, y=479.
- In a locked stream, one line has 799 active pixels: at the next VS fall locked=0 and h_err=1. Two more good frames relock. err_clr then drops h_err.
- Frame with 479 active lines: v_active=479, v_err=1, locked=0.
- Hold hs=1 for 4096+ cycles: timeout=1, locked=0, FSM in SEARCH. The next VS fall gives no evaluation, and errors stay unchanged.
- Assert pixel_rst mid-frame: all outputs are 0 immediately. After release, no frame_start occurs until a real VS falling edge, with no false edges.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video timing constants, pixel type and receiver state encoding
package video_pkg;

  localparam int HDISP_DEF  = 800;
  localparam int VDISP_DEF  = 480;
  localparam int HFP        = 40;
  localparam int HPULSE     = 48;
  localparam int HBP        = 40;
  localparam int VFP        = 13;
  localparam int VPULSE     = 3;
  localparam int VBP        = 29;
  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-register sampler with falling-edge pulse
// Registers reset to 1 so releasing reset on an idle-high sync never looks like an edge.
module sync_edge_det (
  input  logic pixel_clk,
  input  logic pixel_rst,
  input  logic sample,
  output logic fall
);
  logic stage1;
  logic stage2;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      stage1 <= 1'b1;
      stage2 <= 1'b1;
    end else begin
      stage1 <= sample;
      stage2 <= stage1;
    end
  end

  assign fall = stage2 & ~stage1;
endmodule

// File: rtl/video_rx_monitor.sv
// rtl/video_rx_monitor.sv - video receive monitor: pixel coordinates, geometry measurement, lock and error status
module video_rx_monitor
  import video_pkg::*;
#(
  parameter int HDISP       = HDISP_DEF,
  parameter int VDISP       = VDISP_DEF,
  parameter int HCNT_W      = HCNT_W_DEF,
  parameter int VCNT_W      = VCNT_W_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              pixel_clk,
  input  logic              pixel_rst,
  input  logic              hs,
  input  logic              vs,
  input  logic              blank,
  input  rgb_t              rgb,
  input  logic              err_clr,
  output logic              pix_valid,
  output logic [HCNT_W-1:0] pix_x,
  output logic [VCNT_W-1:0] pix_y,
  output rgb_t              pix_rgb,
  output logic              frame_start,
  output logic [HCNT_W-1:0] h_total,
  output logic [VCNT_W-1:0] v_total,
  output logic [HCNT_W-1:0] h_active,
  output logic [VCNT_W-1:0] v_active,
  output logic              locked,
  output logic              h_err,
  output logic              v_err,
  output logic              timeout
);
  localparam int                GOOD_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [HCNT_W-1:0] HMAX    = {HCNT_W{1'b1}};
  localparam logic [VCNT_W-1:0] VMAX    = {VCNT_W{1'b1}};
  localparam logic [HCNT_W-1:0] HDISP_C = HCNT_W'(HDISP);
  localparam logic [VCNT_W-1:0] VDISP_C = VCNT_W'(VDISP);
  localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_FRAMES);

  logic              hs_fall, vs_fall, blank_s;
  rgb_t              rgb_s;
  logic [HCNT_W-1:0] hcnt, act_x, x_now;
  logic [VCNT_W-1:0] line_act, hs_cnt, line_act_le, hs_cnt_le, y_now;
  logic              line_bad, line_bad_le, line_end, frame_good, tmo_hit, eval;
  rx_state_t         state;
  logic [GOOD_W-1:0] good_cnt, good_inc;

  sync_edge_det u_hs_det (.pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .sample(hs), .fall(hs_fall));
  sync_edge_det u_vs_det (.pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .sample(vs), .fall(vs_fall));

  // Line-end results are folded in first so a coincident VS fall sees the closing line.
  always_comb begin
    line_end    = hs_fall && (act_x != '0);
    line_act_le = line_act;
    if (line_end && line_act != VMAX) line_act_le = line_act + 1'b1;
    line_bad_le = line_bad | (line_end && act_x != HDISP_C);
    hs_cnt_le   = hs_cnt;
    if (hs_fall && hs_cnt != VMAX) hs_cnt_le = hs_cnt + 1'b1;
    frame_good  = !line_bad_le && (line_act_le == VDISP_C);
    tmo_hit     = (hcnt == HMAX);
    eval        = vs_fall && !tmo_hit && (state != SEARCH);
    x_now       = hs_fall ? '0 : act_x;
    y_now       = vs_fall ? '0 : line_act_le;
  end

  assign good_inc = good_cnt + 1'b1;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      blank_s   <= 1'b0;
      rgb_s     <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
      act_x     <= '0;
    end else begin
      blank_s   <= blank;
      rgb_s     <= rgb;
      pix_valid <= blank_s;
      if (blank_s) begin
        pix_x   <= x_now;
        pix_y   <= y_now;
        pix_rgb <= rgb_s;
      end
      act_x <= (blank_s && x_now != HMAX) ? x_now + 1'b1 : x_now;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt        <= '0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      hs_cnt      <= '0;
      line_act    <= '0;
      line_bad    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcnt <= hs_fall ? '0 : (tmo_hit ? hcnt : hcnt + 1'b1);
      if (hs_fall) h_total <= tmo_hit ? HMAX : hcnt + 1'b1;
      if (line_end) h_active <= act_x;
      frame_start <= vs_fall;
      if (vs_fall) begin
        v_total  <= hs_cnt_le;
        v_active <= line_act_le;
        hs_cnt   <= '0;
        line_act <= '0;
        line_bad <= 1'b0;
      end else begin
        hs_cnt   <= hs_cnt_le;
        line_act <= line_act_le;
        line_bad <= line_bad_le;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      h_err    <= 1'b0;
      v_err    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (eval && line_bad_le) h_err <= 1'b1;
      else if (err_clr) h_err <= 1'b0;
      if (eval && line_act_le != VDISP_C) v_err <= 1'b1;
      else if (err_clr) v_err <= 1'b0;
      if (tmo_hit) timeout <= 1'b1;
      else if (err_clr) timeout <= 1'b0;

      if (tmo_hit) begin
        state    <= SEARCH;
        locked   <= 1'b0;
        good_cnt <= '0;
      end else if (vs_fall) begin
        case (state)
          SEARCH: begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
          MEASURE: begin
            if (!frame_good) begin
              good_cnt <= '0;
            end else begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (!frame_good) begin
              state    <= MEASURE;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_video_rx_monitor.sv
// tb/tb_video_rx_monitor.sv - scoreboard bench for video_rx_monitor on a reduced 16x8 raster
module tb_video_rx_monitor;
  import video_pkg::*;

  localparam int HD = 16, HFPB = 4, HPW = 4, HBPB = 4, HT = HD + HFPB + HPW + HBPB;
  localparam int VD = 8, VFPB = 2, VPW = 2, VBPB = 3, VT = VD + VFPB + VPW + VBPB;
  localparam int HW = 12, VW = 11;

  logic pixel_clk = 1'b0;
  logic pixel_rst = 1'b1;
  logic hs = 1'b1, vs = 1'b1, blank = 1'b0, err_clr = 1'b0;
  rgb_t rgb = '0;
  logic          pix_valid, frame_start, locked, h_err, v_err, timeout;
  logic [HW-1:0] pix_x, h_total, h_active;
  logic [VW-1:0] pix_y, v_total, v_active;
  rgb_t          pix_rgb;

  video_rx_monitor #(.HDISP(HD), .VDISP(VD), .HCNT_W(HW), .VCNT_W(VW), .LOCK_FRAMES(2)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .hs(hs), .vs(vs), .blank(blank), .rgb(rgb),
    .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total), .h_active(h_active),
    .v_active(v_active), .locked(locked), .h_err(h_err), .v_err(v_err), .timeout(timeout)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    rgb_t          c;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_e;
  int   total = 0, bad = 0, cyc = 0;
  int   fs_count = 0, fs_cyc = -1, lock_cyc = -1, vs_cyc = -1, model_y = 0;
  bit   vs_prev = 0, clr_on_vs = 0, pend_clr = 0;
  logic locked_d = 1'b0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  always @(negedge pixel_clk) begin
    if (!pixel_rst) begin
      if (pix_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pixel_unexpected: got x=%0d y=%0d want no pixel", pix_x, pix_y);
        end else begin
          got_e = exp_q.pop_front();
          if ({pix_x, pix_y, pix_rgb} !== got_e) begin
            bad++;
            $display("FAIL pixel: got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h",
                     pix_x, pix_y, pix_rgb, got_e.x, got_e.y, got_e.c);
          end
        end
      end
      if (frame_start) begin
        fs_count++;
        fs_cyc = cyc;
      end
      if (locked && !locked_d) lock_cyc = cyc;
    end
    locked_d = locked;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic drive_line(input int nact, input bit vlow);
    pix_t pe;
    for (int c = 0; c < HT; c++) begin
      @(posedge pixel_clk); #1;
      err_clr  = pend_clr;
      pend_clr = 0;
      vs = ~vlow;
      if (vlow && !vs_prev) begin
        vs_cyc  = cyc;
        model_y = 0;
        if (clr_on_vs) pend_clr = 1;
      end
      vs_prev = vlow;
      hs      = !(c >= HD + HFPB && c < HD + HFPB + HPW);
      blank   = (c < nact);
      rgb     = 24'($urandom);
      if (c < nact) begin
        pe.x = HW'(c);
        pe.y = VW'(model_y);
        pe.c = rgb;
        exp_q.push_back(pe);
      end
    end
    if (nact > 0) model_y++;
  endtask

  task automatic drive_frame(input int nlines, input int bad_line, input int bad_nact);
    for (int l = 0; l < VT; l++)
      drive_line((l >= nlines) ? 0 : ((l == bad_line) ? bad_nact : HD),
                 (l >= VD + VFPB) && (l < VD + VFPB + VPW));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pixel_clk); #1;
      hs = 1'b1; vs = 1'b1; blank = 1'b0; err_clr = 1'b0;
    end
    vs_prev = 0;
  endtask

  task automatic pulse_clr();
    @(posedge pixel_clk); #1; err_clr = 1'b1;
    @(posedge pixel_clk); #1; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pixel_clk);
    #1;
    total++;
    if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, h_total, v_total, h_active, v_active,
         locked, h_err, v_err, timeout} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs want all 0");
    end
    pixel_rst = 1'b0;
    idle(10);
    total++;
    if (fs_count !== 0) begin bad++; $display("FAIL reset_no_frame: got %0d want 0", fs_count); end
  endtask

  task automatic test_nominal();
    drive_frame(VD, -1, 0);
    drive_frame(VD, -1, 0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL nominal_early_lock: got %b want 0", locked); end
    drive_frame(VD, -1, 0);
    total++;
    if (lock_cyc !== vs_cyc + 2) begin bad++; $display("FAIL nominal_lock_time: got %0d want %0d", lock_cyc, vs_cyc + 2); end
    total++;
    if (fs_cyc !== vs_cyc + 2 || fs_count !== 3) begin
      bad++; $display("FAIL nominal_frame_start: got cyc=%0d n=%0d want cyc=%0d n=3", fs_cyc, fs_count, vs_cyc + 2);
    end
    total++;
    if ({h_total, v_total, h_active, v_active} !== {HW'(HT), VW'(VT), HW'(HD), VW'(VD)}) begin
      bad++; $display("FAIL nominal_geometry: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                      h_total, v_total, h_active, v_active, HT, VT, HD, VD);
    end
    total++;
    if ({locked, h_err, v_err, timeout} !== 4'b1000) begin
      bad++; $display("FAIL nominal_status: got %b want 1000", {locked, h_err, v_err, timeout});
    end
    total++;
    if (pix_x !== HW'(HD - 1) || pix_y !== VW'(VD - 1)) begin
      bad++; $display("FAIL last_pixel: got x=%0d y=%0d want x=%0d y=%0d", pix_x, pix_y, HD - 1, VD - 1);
    end
  endtask

  task automatic test_short_line();
    drive_frame(VD, 3, HD - 1);
    total++;
    if ({locked, h_err, v_err} !== 3'b010) begin
      bad++; $display("FAIL short_line_status: got %b want 010", {locked, h_err, v_err});
    end
    drive_frame(VD, -1, 0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", locked); end
    drive_frame(VD, -1, 0);
    total++;
    if (locked !== 1'b1 || lock_cyc !== vs_cyc + 2 || h_err !== 1'b1) begin
      bad++; $display("FAIL relock: got locked=%b cyc=%0d h_err=%b want 1 %0d 1", locked, lock_cyc, h_err, vs_cyc + 2);
    end
    pulse_clr();
    total++;
    if (h_err !== 1'b0) begin bad++; $display("FAIL h_err_clear: got %b want 0", h_err); end
  endtask

  task automatic test_short_frame();
    drive_frame(VD - 1, -1, 0);
    total++;
    if ({v_active, v_err, locked, h_err} !== {VW'(VD - 1), 3'b100}) begin
      bad++; $display("FAIL short_frame: got v_active=%0d v_err=%b locked=%b h_err=%b want %0d 1 0 0",
                      v_active, v_err, locked, h_err, VD - 1);
    end
    drive_frame(VD, -1, 0);
    drive_frame(VD, -1, 0);
    pulse_clr();
    total++;
    if ({locked, v_err} !== 2'b10) begin bad++; $display("FAIL short_frame_recover: got %b want 10", {locked, v_err}); end
  endtask

  task automatic test_err_clr_collision();
    clr_on_vs = 1;
    drive_frame(VD, 2, HD + 1);
    clr_on_vs = 0;
    total++;
    if ({h_err, locked} !== 2'b10) begin
      bad++; $display("FAIL clr_collision: got h_err=%b locked=%b want 1 0", h_err, locked);
    end
    pulse_clr();
    drive_frame(VD, -1, 0);
    drive_frame(VD, -1, 0);
    total++;
    if ({locked, h_err} !== 2'b10) begin bad++; $display("FAIL collision_recover: got %b want 10", {locked, h_err}); end
  endtask

  task automatic test_timeout();
    idle(4200);
    total++;
    if ({timeout, locked} !== 2'b10) begin bad++; $display("FAIL timeout: got %b want 10", {timeout, locked}); end
    drive_frame(VD - 1, -1, 0);
    total++;
    if ({timeout, locked, h_err, v_err, v_active} !== {4'b1000, VW'(VD - 1)}) begin
      bad++; $display("FAIL timeout_search: got t=%b l=%b h=%b v=%b va=%0d want 1 0 0 0 %0d",
                      timeout, locked, h_err, v_err, v_active, VD - 1);
    end
    pulse_clr();
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid_frame();
    int fs_before;
    for (int l = 0; l < 3; l++) drive_line(HD, 1'b0);
    idle(3);
    @(posedge pixel_clk); #1;
    pixel_rst = 1'b1;
    #1;
    total++;
    if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, h_total, v_total, h_active, v_active,
         locked, h_err, v_err, timeout} !== '0) begin
      bad++; $display("FAIL midframe_reset: got nonzero outputs want all 0");
    end
    exp_q.delete();
    repeat (3) @(posedge pixel_clk);
    #1;
    pixel_rst = 1'b0;
    model_y   = 0;
    vs_prev   = 0;
    fs_before = fs_count;
    idle(20);
    total++;
    if (fs_count !== fs_before) begin bad++; $display("FAIL false_edge: got %0d want %0d", fs_count, fs_before); end
    drive_frame(VD, -1, 0);
    total++;
    if (fs_count !== fs_before + 1 || fs_cyc !== vs_cyc + 2 || locked !== 1'b0) begin
      bad++; $display("FAIL post_reset_frame: got n=%0d cyc=%0d locked=%b want %0d %0d 0",
                      fs_count, fs_cyc, locked, fs_before + 1, vs_cyc + 2);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_short_frame();
    test_err_clr_collision();
    test_timeout();
    test_reset_mid_frame();
    idle(4);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
